// File: rtl/pulse_meas_pkg.sv
// Shared types and constants for the pulse pattern decoder.
// FSM encodings, default clock/tick rates and a width helper.
package pulse_meas_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      HIGH = 2'd1,
      LOW  = 2'd2
   } state_t;

   localparam int unsigned CLK_HZ_DEF  = 100_000_000;
   localparam int unsigned TICK_HZ_DEF = 1000;

   function automatic int unsigned bits_for(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/input_debouncer.sv
// Two-flop synchroniser plus tick-based debouncer.
// A level change is accepted after DEBOUNCE_TICKS differing ticks.
module input_debouncer
   import pulse_meas_pkg::*;
#(
   parameter int unsigned DEBOUNCE_TICKS = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic tick,
   input  logic raw,
   output logic level
);

   localparam int unsigned DEB_W = bits_for(DEBOUNCE_TICKS + 1);
   localparam logic [DEB_W-1:0] DEB_MAX = DEB_W'(DEBOUNCE_TICKS - 1);

   logic [1:0]       sync_q;
   logic             sync;
   logic [DEB_W-1:0] deb_cnt;

   assign sync = sync_q[1];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= '0;
      end else begin
         sync_q <= {sync_q[0], raw};
      end
   end

   // Both edges see the same delay, so phase durations are preserved.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         deb_cnt <= '0;
         level   <= 1'b0;
      end else if (tick) begin
         if (sync != level) begin
            if (deb_cnt == DEB_MAX) begin
               level   <= ~level;
               deb_cnt <= '0;
            end else begin
               deb_cnt <= deb_cnt + 1'b1;
            end
         end else begin
            deb_cnt <= '0;
         end
      end
   end

endmodule

// File: rtl/pulse_pattern_decoder.sv
// Measures high/low phase durations of a debounced input in ticks.
// Define PULSE_PERIOD_OUT_EN to add the registered period_ticks output.
module pulse_pattern_decoder
   import pulse_meas_pkg::*;
#(
   parameter int unsigned CLK_HZ         = CLK_HZ_DEF,
   parameter int unsigned TICK_HZ        = TICK_HZ_DEF,
   parameter int unsigned DEBOUNCE_TICKS = 4,
   parameter int unsigned CNT_W          = 16
) (
   input  logic             CLK100MHZ,
   input  logic             CPU_RESETN,
   input  logic             sig_in,
   output logic             tick_out,
   output logic             sig_level,
   output logic [CNT_W-1:0] on_ticks,
   output logic [CNT_W-1:0] off_ticks,
   output logic             sat,
`ifdef PULSE_PERIOD_OUT_EN
   output logic [CNT_W:0]   period_ticks,
`endif
   output logic             meas_valid
);

   localparam int unsigned DIV   = CLK_HZ / TICK_HZ;
   localparam int unsigned DIV_W = bits_for(DIV);
   localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(DIV - 1);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic [DIV_W-1:0] div_cnt;
   logic             tick;
   logic             lvl_d;
   logic             rise;
   logic             fall;

   state_t           state;
   state_t           state_nx;

   logic             clr_lo;
   logic             clr_hv;
   logic             ld_hold;
   logic             clr_hi;
   logic             pub;

   logic [CNT_W-1:0] hi_cnt;
   logic             hi_sat;
   logic [CNT_W-1:0] lo_cnt;
   logic             lo_sat;
   logic [CNT_W-1:0] hold_cnt;
   logic             hold_sat;
   logic             hi_valid;

   assign tick = (div_cnt == DIV_MAX);

   always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
      if (!CPU_RESETN) begin
         div_cnt  <= '0;
         tick_out <= 1'b0;
      end else begin
         div_cnt  <= tick ? '0 : div_cnt + 1'b1;
         tick_out <= tick;
      end
   end

   input_debouncer #(
      .DEBOUNCE_TICKS(DEBOUNCE_TICKS)
   ) u_deb (
      .clk  (CLK100MHZ),
      .rst_n(CPU_RESETN),
      .tick (tick),
      .raw  (sig_in),
      .level(sig_level)
   );

   always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
      if (!CPU_RESETN) begin
         lvl_d <= 1'b0;
      end else begin
         lvl_d <= sig_level;
      end
   end

   assign rise = sig_level & ~lvl_d;
   assign fall = ~sig_level & lvl_d;

   always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
      if (!CPU_RESETN) begin
         state <= IDLE;
      end else begin
         state <= state_nx;
      end
   end

   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE:    if (fall) state_nx = LOW;
         HIGH:    if (fall) state_nx = LOW;
         LOW:     if (rise) state_nx = HIGH;
         default: state_nx = IDLE;
      endcase
   end

   // A rise seen from IDLE may be a reset artefact, so it is ignored.
   always_comb begin
      clr_lo  = 1'b0;
      clr_hv  = 1'b0;
      ld_hold = 1'b0;
      clr_hi  = 1'b0;
      pub     = 1'b0;
      unique case (state)
         IDLE: begin
            clr_lo = fall;
            clr_hv = fall;
         end
         HIGH: begin
            ld_hold = fall;
            clr_lo  = fall;
         end
         LOW: begin
            clr_hi = rise;
            pub    = rise & hi_valid;
         end
         default: ;
      endcase
   end

   always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
      if (!CPU_RESETN) begin
         hi_cnt <= '0;
         hi_sat <= 1'b0;
      end else if (clr_hi) begin
         hi_cnt <= '0;
         hi_sat <= 1'b0;
      end else if (tick && state == HIGH && sig_level) begin
         if (hi_cnt == CNT_MAX) begin
            hi_sat <= 1'b1;
         end else begin
            hi_cnt <= hi_cnt + 1'b1;
         end
      end
   end

   always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
      if (!CPU_RESETN) begin
         lo_cnt <= '0;
         lo_sat <= 1'b0;
      end else if (clr_lo) begin
         lo_cnt <= '0;
         lo_sat <= 1'b0;
      end else if (tick && state == LOW && !sig_level) begin
         if (lo_cnt == CNT_MAX) begin
            lo_sat <= 1'b1;
         end else begin
            lo_cnt <= lo_cnt + 1'b1;
         end
      end
   end

   always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
      if (!CPU_RESETN) begin
         hold_cnt <= '0;
         hold_sat <= 1'b0;
         hi_valid <= 1'b0;
      end else if (ld_hold) begin
         hold_cnt <= hi_cnt;
         hold_sat <= hi_sat;
         hi_valid <= 1'b1;
      end else if (clr_hv) begin
         hi_valid <= 1'b0;
      end
   end

   always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
      if (!CPU_RESETN) begin
         on_ticks   <= '0;
         off_ticks  <= '0;
         sat        <= 1'b0;
         meas_valid <= 1'b0;
      end else begin
         meas_valid <= pub;
         if (pub) begin
            on_ticks  <= hold_cnt;
            off_ticks <= lo_cnt;
            sat       <= hold_sat | lo_sat;
         end
      end
   end

`ifdef PULSE_PERIOD_OUT_EN
   always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
      if (!CPU_RESETN) begin
         period_ticks <= '0;
      end else if (pub) begin
         period_ticks <= {1'b0, hold_cnt} + {1'b0, lo_cnt};
      end
   end
`endif

endmodule

// File: tb/tb_pulse_pattern_decoder.sv
// Directed bench for pulse_pattern_decoder (DIV=10, 4-tick debounce).
// A CNT_W=4 instance shares the stimulus for the saturation case.
module tb_pulse_pattern_decoder;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic sig_in = 1'b0;

   logic        tick_out, sig_level, sat, meas_valid;
   logic [15:0] on_ticks, off_ticks;
   logic        tick4, lvl4, sat4, mv4;
   logic [3:0]  on4, off4;
`ifdef PULSE_PERIOD_OUT_EN
   logic [16:0] period;
   logic [4:0]  period4;
`endif

   int checks = 0;
   int errors = 0;
   int strobes = 0;
   int strobes4 = 0;
   int long_mv = 0;
   int falls = 0;
   int cap_on = 0, cap_off = 0, cap_sat = 0, cap_per = 0;
   int cap_on4 = 0, cap_off4 = 0, cap_sat4 = 0;
   logic mv_prev = 1'b0;
   logic lvl_prev = 1'b0;

   always #5 clk = ~clk;

   pulse_pattern_decoder #(
      .CLK_HZ(1000), .TICK_HZ(100), .DEBOUNCE_TICKS(4), .CNT_W(16)
   ) dut (
      .CLK100MHZ (clk),
      .CPU_RESETN(rst_n),
      .sig_in    (sig_in),
      .tick_out  (tick_out),
      .sig_level (sig_level),
      .on_ticks  (on_ticks),
      .off_ticks (off_ticks),
      .sat       (sat),
`ifdef PULSE_PERIOD_OUT_EN
      .period_ticks(period),
`endif
      .meas_valid(meas_valid)
   );

   pulse_pattern_decoder #(
      .CLK_HZ(1000), .TICK_HZ(100), .DEBOUNCE_TICKS(4), .CNT_W(4)
   ) dut4 (
      .CLK100MHZ (clk),
      .CPU_RESETN(rst_n),
      .sig_in    (sig_in),
      .tick_out  (tick4),
      .sig_level (lvl4),
      .on_ticks  (on4),
      .off_ticks (off4),
      .sat       (sat4),
`ifdef PULSE_PERIOD_OUT_EN
      .period_ticks(period4),
`endif
      .meas_valid(mv4)
   );

   always @(negedge clk) begin
      if (meas_valid) begin
         strobes++;
         cap_on  = on_ticks;
         cap_off = off_ticks;
         cap_sat = sat;
`ifdef PULSE_PERIOD_OUT_EN
         cap_per = period;
`endif
         if (mv_prev) long_mv++;
      end
      mv_prev = meas_valid;
      if (lvl_prev && !sig_level) falls++;
      lvl_prev = sig_level;
      if (mv4) begin
         strobes4++;
         cap_on4  = on4;
         cap_off4 = off4;
         cap_sat4 = sat4;
      end
   end

   task automatic wait_tick();
      int n = 0;
      do begin
         @(posedge clk);
         #1;
         n++;
      end while (!tick_out && n < 40);
      if (!tick_out) begin
         checks++;
         errors++;
         $display("FAIL tick_timeout got 0 want 1");
      end
   endtask

   task automatic phase(input logic v, input int n);
      @(posedge clk);
      #1;
      sig_in = v;
      repeat (n) wait_tick();
   endtask

   task automatic do_reset(input logic v);
      rst_n = 1'b0;
      sig_in = v;
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;
      wait_tick();
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      sig_in = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      checks++;
      if (on_ticks !== 16'd0 || off_ticks !== 16'd0) begin
         errors++;
         $display("FAIL reset_counts got %0d/%0d want 0/0", on_ticks, off_ticks);
      end
      checks++;
      if ({tick_out, sig_level, sat, meas_valid} !== 4'b0) begin
         errors++;
         $display("FAIL reset_flags got %b want 0000",
                  {tick_out, sig_level, sat, meas_valid});
      end
`ifdef PULSE_PERIOD_OUT_EN
      checks++;
      if (period !== 17'd0) begin
         errors++;
         $display("FAIL reset_period got %0d want 0", period);
      end
`endif
   endtask

   task automatic test_square();
      int base;
      do_reset(1'b0);
      base = strobes;
      phase(1'b1, 8); phase(1'b0, 4); phase(1'b1, 8); phase(1'b0, 4);
      checks++;
      if (strobes - base !== 0) begin
         errors++;
         $display("FAIL sq_early got %0d want 0", strobes - base);
      end
      phase(1'b1, 8);
      checks++;
      if (strobes - base !== 1 || cap_on !== 8 || cap_off !== 4 || cap_sat !== 0) begin
         errors++;
         $display("FAIL sq_first got n=%0d on=%0d off=%0d sat=%0d want 1/8/4/0",
                  strobes - base, cap_on, cap_off, cap_sat);
      end
`ifdef PULSE_PERIOD_OUT_EN
      checks++;
      if (cap_per !== 12) begin
         errors++;
         $display("FAIL sq_period got %0d want 12", cap_per);
      end
`endif
      phase(1'b0, 4); phase(1'b1, 8);
      checks++;
      if (strobes - base !== 2 || cap_on !== 8 || cap_off !== 4) begin
         errors++;
         $display("FAIL sq_repeat got n=%0d on=%0d off=%0d want 2/8/4",
                  strobes - base, cap_on, cap_off);
      end
      checks++;
      if (on_ticks !== 16'd8 || off_ticks !== 16'd4) begin
         errors++;
         $display("FAIL sq_hold got %0d/%0d want 8/4", on_ticks, off_ticks);
      end
      checks++;
      if (long_mv !== 0) begin
         errors++;
         $display("FAIL sq_strobe_width got %0d want 0", long_mv);
      end
   endtask

   task automatic test_glitch();
      int base, fbase;
      do_reset(1'b0);
      base = strobes;
      fbase = falls;
      phase(1'b1, 8); phase(1'b0, 4); phase(1'b1, 8); phase(1'b0, 4);
      phase(1'b1, 4); phase(1'b0, 2); phase(1'b1, 2);
      phase(1'b0, 4); phase(1'b1, 8);
      checks++;
      if (falls - fbase !== 3) begin
         errors++;
         $display("FAIL gl_falls got %0d want 3", falls - fbase);
      end
      checks++;
      if (strobes - base !== 2 || cap_on !== 8 || cap_off !== 4) begin
         errors++;
         $display("FAIL gl_meas got n=%0d on=%0d off=%0d want 2/8/4",
                  strobes - base, cap_on, cap_off);
      end
   endtask

   task automatic test_saturate();
      int base, base4;
      do_reset(1'b0);
      base = strobes;
      base4 = strobes4;
      phase(1'b1, 8); phase(1'b0, 4); phase(1'b1, 20);
      phase(1'b0, 4); phase(1'b1, 8);
      checks++;
      if (strobes4 - base4 !== 1 || cap_on4 !== 15 || cap_off4 !== 4 || cap_sat4 !== 1) begin
         errors++;
         $display("FAIL sat_w4 got n=%0d on=%0d off=%0d sat=%0d want 1/15/4/1",
                  strobes4 - base4, cap_on4, cap_off4, cap_sat4);
      end
      checks++;
      if (sat4 !== 1'b1) begin
         errors++;
         $display("FAIL sat_hold got %b want 1", sat4);
      end
      checks++;
      if (strobes - base !== 1 || cap_on !== 20 || cap_sat !== 0) begin
         errors++;
         $display("FAIL sat_w16 got n=%0d on=%0d sat=%0d want 1/20/0",
                  strobes - base, cap_on, cap_sat);
      end
`ifdef PULSE_PERIOD_OUT_EN
      checks++;
      if (cap_per !== 24) begin
         errors++;
         $display("FAIL sat_period got %0d want 24", cap_per);
      end
`endif
   endtask

   task automatic test_reset_mid();
      int base;
      do_reset(1'b0);
      phase(1'b1, 8); phase(1'b0, 4); phase(1'b1, 8);
      phase(1'b0, 4); phase(1'b1, 6);
      #3;
      rst_n = 1'b0;
      #1;
      checks++;
      if (on_ticks !== 16'd0 || off_ticks !== 16'd0 || sat !== 1'b0) begin
         errors++;
         $display("FAIL mid_counts got %0d/%0d/%b want 0/0/0",
                  on_ticks, off_ticks, sat);
      end
      checks++;
      if ({tick_out, sig_level, meas_valid} !== 3'b0) begin
         errors++;
         $display("FAIL mid_flags got %b want 000",
                  {tick_out, sig_level, meas_valid});
      end
      base = strobes;
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;
      wait_tick();
      phase(1'b1, 5); phase(1'b0, 4); phase(1'b1, 8);
      checks++;
      if (strobes - base !== 0) begin
         errors++;
         $display("FAIL mid_stale got %0d want 0", strobes - base);
      end
      phase(1'b0, 4); phase(1'b1, 8);
      checks++;
      if (strobes - base !== 1 || cap_on !== 8 || cap_off !== 4) begin
         errors++;
         $display("FAIL mid_restart got n=%0d on=%0d off=%0d want 1/8/4",
                  strobes - base, cap_on, cap_off);
      end
   endtask

   task automatic test_held_high();
      int base;
      rst_n = 1'b0;
      sig_in = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;
      base = strobes;
      repeat (3) wait_tick();
      checks++;
      if (sig_level !== 1'b0) begin
         errors++;
         $display("FAIL held_pre got %b want 0", sig_level);
      end
      wait_tick();
      checks++;
      if (sig_level !== 1'b1) begin
         errors++;
         $display("FAIL held_level got %b want 1", sig_level);
      end
      repeat (30) wait_tick();
      checks++;
      if (strobes - base !== 0) begin
         errors++;
         $display("FAIL held_strobe got %0d want 0", strobes - base);
      end
   endtask

   initial begin
      test_reset();
      test_square();
      test_glitch();
      test_saturate();
      test_reset_mid();
      test_held_high();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/pulse_pattern_decoder.md
Name: pulse_pattern_decoder

Overview:
- Input-side counterpart to the LED pattern generators: measures the on/off timing of an external on/off signal such as a switch, sensor or looped-back LED line.
- Derives an internal 1 kHz tick from CLK100MHZ.
- Synchronises and debounces the input, then counts high-phase and low-phase durations in ticks.
- Publishes each complete period (rising edge to rising edge) with a one-cycle valid strobe.

Parameters:
CLK_HZ, 100_000_000, input clock frequency
TICK_HZ, 1000, measurement tick rate; DIV = CLK_HZ/TICK_HZ (integer, >=2)
DEBOUNCE_TICKS, 4, consecutive differing ticks required to accept a level change (>=1)
CNT_W, 16, width of the duration counters

Ports:
CLK100MHZ  in  1  system clock
CPU_RESETN  in  1  asynchronous active-low reset
sig_in  in  1  asynchronous raw input
tick_out  out  1  one-cycle pulse each tick (bench alignment/debug)
sig_level  out  1  debounced level
on_ticks  out  CNT_W  last complete high-phase duration in ticks
off_ticks  out  CNT_W  last complete low-phase duration in ticks
sat  out  1  on_ticks or off_ticks saturated in the published period
meas_valid  out  1  one-cycle strobe; on_ticks/off_ticks/sat updated in the same cycle

Behaviour:
- Reset: async on CPU_RESETN low. All registers and outputs go to 0; FSM enters IDLE; hi_valid=0.
- Synchroniser: two flops on sig_in, giving sync. All later logic uses sync only.
- Tick generator:
  - div_cnt counts 0..DIV-1 and wraps.
  - tick is high for the cycle where div_cnt==DIV-1.
  - tick_out = tick, registered.
- Debouncer (evaluated on tick cycles only):
  - If sync != sig_level, deb_cnt increments. When it reaches DEBOUNCE_TICKS, sig_level toggles and deb_cnt clears.
  - If sync == sig_level, deb_cnt clears.
  - Net effect: both edges are delayed equally, so durations are preserved.
- Edge detect:
  - lvl_d is sig_level delayed by one clock.
  - rise = sig_level & ~lvl_d; fall = ~sig_level & lvl_d.
  - Edges therefore occur the cycle after a tick and never coincide with a tick.
- Phase counting: on each tick, hi_cnt increments if sig_level==1 in HIGH, or lo_cnt increments if sig_level==0 in LOW.
  - Each counter saturates at 2^CNT_W-1 and sets its own sat flag.
  - Counted value = number of ticks between the two debounced edges bounding the phase.
- FSM states: IDLE, HIGH, LOW.
  - IDLE: ignore rise, because a debounced rise straight after reset may be a false edge. On fall: go to LOW, clear lo_cnt and lo_sat, set hi_valid=0.
  - HIGH: on fall, latch hi_cnt and hi_sat into hi_hold, set hi_valid=1, clear lo_cnt and lo_sat, go to LOW.
  - LOW: on rise, if hi_valid, publish on_ticks=hi_hold, off_ticks=lo_cnt, sat=hi_sat|lo_sat, and pulse meas_valid. Then clear hi_cnt and hi_sat and go to HIGH.
- First strobe: occurs at the second debounced rise after the first debounced fall.
- Outputs on_ticks, off_ticks and sat hold their values between strobes.
- Reset mid-operation: everything clears immediately. No stale strobe is produced; the sequence restarts from IDLE.

Optional Feature:
PULSE_PERIOD_OUT_EN
- Defined: adds output period_ticks [CNT_W:0] = on_ticks + off_ticks. It is registered and updated in the same cycle as meas_valid, and resets to 0.
- Undefined: the port and adder are absent; behaviour is otherwise identical.

Decomposition:
- Shared package/header pulse_meas_pkg holds:
  - FSM state encodings: IDLE=2'd0, HIGH=2'd1, LOW=2'd2.
  - Default CLK_HZ and TICK_HZ constants.
  - DIV width via $clog2.
- One sub-module, input_debouncer: owns the synchroniser and deb_cnt. Inputs are clock, reset, tick and raw input; output is sig_level.
- Tick generator and FSM stay in the top module.

Test Plan:
- For fast simulation, all scenarios use CLK_HZ=1000, TICK_HZ=100 (DIV=10), DEBOUNCE_TICKS=4.
- Square wave, 8 ticks high / 4 ticks low, toggled 1 clk after tick_out -> at the third debounced rise: meas_valid=1 for 1 clk, on_ticks=8, off_ticks=4, sat=0. Repeats every 12 ticks.
- 2-tick low glitch inside an 8-tick high phase -> sig_level stays 1; next strobe shows on_ticks=8.
- CNT_W=4, input high for 20 ticks then low 4 ticks, with a prior full cycle -> on_ticks=15, off_ticks=4, sat=1.
- CPU_RESETN pulsed low mid-HIGH -> all outputs 0 asynchronously; no meas_valid until fall, rise, fall, rise after release.
- sig_in held 1 through reset release -> sig_level=1 after 4 ticks; meas_valid never asserts.
- PULSE_PERIOD_OUT_EN defined, 8/4 square wave -> period_ticks=12 coincident with meas_valid.
